// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RISC-V datapath.
// Optional: define CTRL_ILLEGAL_TRAP_EN to halt on an illegal instruction instead of treating it as a NOP.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             alu_src,
    output logic             mem_write,
    output logic             mem_read,
    output logic [3:0]       alu_cc,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    localparam logic [3:0] CC_ADD = 4'b0010;
    localparam logic [3:0] CC_SUB = 4'b0110;
    localparam logic [3:0] CC_XOR = 4'b1100;
    localparam logic [3:0] CC_OR  = 4'b0001;
    localparam logic [3:0] CC_AND = 4'b0000;
    localparam logic [3:0] CC_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [2:0]       f3_q, f3_d;
    logic [6:0]       f7_q, f7_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Returns {legal, alu_cc} for one set of instruction fields.
    function automatic logic [4:0] decode_fields(input logic [6:0] op,
                                                 input logic [2:0] f3,
                                                 input logic [6:0] f7);
        logic       legal;
        logic [3:0] cc;
        legal = 1'b1;
        cc    = CC_ADD;
        case (op)
            OP_R, OP_I: begin
                case (f3)
                    3'b000: begin
                        if (op == OP_I || f7 == 7'b0000000) cc = CC_ADD;
                        else if (f7 == 7'b0100000)          cc = CC_SUB;
                        else                                legal = 1'b0;
                    end
                    3'b100:  cc = CC_XOR;
                    3'b110:  cc = CC_OR;
                    3'b111:  cc = CC_AND;
                    3'b010:  cc = CC_SLT;
                    default: legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW: cc = CC_ADD;
            default:      legal = 1'b0;
        endcase
        return {legal, cc};
    endfunction

    logic [4:0] dec_in;
    logic [4:0] dec_held;
    logic       op_is_mem;
    logic       op_uses_imm;

    always_comb begin
        dec_in      = decode_fields(opcode, funct3, funct7);
        dec_held    = decode_fields(op_q, f3_q, f7_q);
        op_is_mem   = (op_q == OP_LW) || (op_q == OP_SW);
        op_uses_imm = op_is_mem || (op_q == OP_I);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        f3_d      = f3_q;
        f7_d      = f7_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = opcode;
                f3_d = funct3;
                f7_d = funct7;
                if (dec_in[4]) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
`else
                    state_d   = S_FETCH;
                    count_d   = count_q + CNT_W'(1);
`endif
                end
            end
            S_EXEC: begin
                state_d = op_is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                count_d = count_q + CNT_W'(1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Strobes are decoded from the registered state and held fields; only the
    // FETCH handshake looks at mem_ready directly. Everything is zero while in reset.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem2reg     = 1'b0;
        alu_src     = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        alu_cc      = 4'b0000;
        illegal     = 1'b0;
        instr_count = '0;
        if (rst) begin
            illegal     = illegal_q;
            instr_count = count_q;
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    pc_write = mem_ready;
                    ir_write = mem_ready;
                end
                S_EXEC: begin
                    alu_cc  = dec_held[3:0];
                    alu_src = op_uses_imm;
                end
                S_MEM: begin
                    alu_cc    = dec_held[3:0];
                    alu_src   = 1'b1;
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    alu_cc    = dec_held[3:0];
                    alu_src   = op_uses_imm;
                    reg_write = 1'b1;
                    mem2reg   = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the RISC-V `Data_path`. It replaces the single-cycle combinational control with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the datapath control strobes (`reg_write`, `mem2reg`, `alu_src`, `mem_write`, `mem_read`, `alu_cc`) from the `opcode`/`funct3`/`funct7` fields the datapath returns. It handshakes with a memory that may stall, and counts retired instructions.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `opcode` input 7: instruction opcode from datapath IR.
- `funct3` input 3: funct3 from datapath IR.
- `funct7` input 7: funct7 from datapath IR.
- `mem_ready` input 1: memory completes current fetch/load/store this cycle.
- `pc_write` output 1: advance PC (PC+4).
- `ir_write` output 1: load instruction register.
- `reg_write` output 1: register-file write enable.
- `mem2reg` output 1: writeback source is memory data.
- `alu_src` output 1: ALU operand B is immediate.
- `mem_write` output 1: data-memory store strobe.
- `mem_read` output 1: memory read request (fetch or load).
- `alu_cc` output 4: ALU operation code.
- `illegal` output 1: sticky unsupported-opcode flag.
- `instr_count` output CNT_W: retired instructions.

## Operation
- Opcodes: R_TYPE 0110011, RTYPEI 0010011, LW 0000011, SW 0100011; all others illegal.
- `alu_cc`: 0010 add, 0110 sub, 1100 xor, 0001 or, 0000 and, 0111 slt.
- R_TYPE: funct3 000 gives add if funct7 = 0000000 and sub if funct7 = 0100000. funct3 100 gives xor, 110 or, 111 and, 010 slt.
- RTYPEI: funct3 000 is always add (funct7 ignored). Others decode as for R_TYPE.
- LW and SW use add. Any other funct3 combination is illegal.
- `opcode`/`funct3`/`funct7` are captured into internal registers in DECODE. They are held until the next DECODE.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `mem_read`=1. On `mem_ready`, assert `ir_write` and `pc_write` for that cycle and go to DECODE. Otherwise hold.
- DECODE: latch fields. Legal instruction goes to EXEC; illegal goes per Configuration.
- EXEC: `alu_cc` valid. `alu_src`=1 for RTYPEI/LW/SW. R/I go to WB; LW/SW go to MEM.
- MEM, load: `mem_read`=1, `alu_src`=1. On `mem_ready` go to WB.
- MEM, store: `mem_write`=1, `alu_src`=1. On `mem_ready` go to FETCH and retire.
- WB: `reg_write`=1 for one cycle. `mem2reg`=1 for LW. Retire, then go to FETCH.
- Retire: `instr_count` increments by 1 and wraps from all-ones to 0.
- `alu_cc` and `alu_src` are held in EXEC, MEM and WB. Outside those states they are 0000/0.
- All strobes not listed for a state are 0.

## Timing
- Outputs are Moore (decoded from the registered state and latched fields). There is no combinational path from `mem_ready` to any strobe except `ir_write`/`pc_write` in FETCH.
- `rst`=0 at a rising edge sets state to FETCH, `instr_count` to 0, `illegal` to 0 and the latched fields to 0.
- While `rst`=0, all outputs are forced to 0. `mem_read` rises in the first cycle after `rst` returns to 1.
- Minimum latency with `mem_ready` tied high:
  - R/I: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle (`mem_ready`=0) in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored in DECODE, EXEC, WB and HALT.
- Reset asserted in any state, including a MEM stall, aborts the instruction: no `reg_write`, no count increment.
- When the count wraps, `illegal` is unaffected.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction in DECODE sets `illegal`=1 and enters HALT.
  - HALT drives all strobes 0 and holds until reset.
  - The instruction is not retired.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction sets `illegal`=1 (sticky), is treated as NOP and returns to FETCH.
  - It is retired (count +1) and HALT is unreachable.

## Test plan
- Reset, then `add` (opcode 0110011, f3 000, f7 0000000) with `mem_ready`=1:
  - FETCH/DECODE/EXEC/WB over 4 cycles.
  - `alu_cc`=0010 in EXEC.
  - `reg_write`=1 in WB only.
  - `instr_count`=1.
- `sub` R-type (f7 0100000): `alu_cc`=0110. The same fields as RTYPEI give `alu_cc`=0010 with `alu_src`=1.
- LW with `mem_ready` low for 3 cycles in MEM:
  - Total 8 cycles.
  - `mem2reg`=1 and `reg_write`=1 in one WB cycle.
  - No `reg_write` during the stall.
- SW:
  - `mem_write`=1 only in MEM.
  - Return to FETCH with no WB.
  - `reg_write` never 1.
  - Count +1.
- Opcode 1111111:
  - With `CTRL_ILLEGAL_TRAP_EN`, `illegal`=1, all strobes stay 0 for 10 cycles and the count is unchanged.
  - Without it, `illegal`=1, the next FETCH follows after DECODE and the count +1.
- Assert `rst`=0 mid-LW stall:
  - Next cycle all outputs are 0 and `instr_count`=0.
  - After release, FETCH restarts.
